// File: rtl/i2c_slave_regs.sv
// ---------------------------------------------------------------------------
// i2c_slave_regs
//
// I2C target that gives an external I2C master read/write access to an 8-bit
// register space through a simple synchronous register port.
//
// Bus protocol
//   START, <DEV_ADDR,W>, <pointer>, <data>...  STOP
//       Each data byte is written to the pointer address, and then the
//       pointer increments.
//   START, <DEV_ADDR,W>, <pointer>, Sr, <DEV_ADDR,R>, <data>... NACK, STOP
//       Each data byte is read from the pointer address, and then the
//       pointer increments. A repeated START keeps the pointer.
//   The pointer is 8 bits wide and wraps from 0xFF to 0x00.
//   The slave never stretches the clock. It expects clk >= 100x SCL.
//
// Ports
//   clk, rst_n               system clock, asynchronous active-low reset
//   i2c_scl_i/_o/_t          SCL pin. The slave never drives it (o=0, t=1).
//   i2c_sda_i/_o/_t          SDA pin. o=0; t=0 pulls SDA low.
//   reg_addr                 register address of the current access
//   reg_wr_en, reg_wr_data   one-cycle write strobe and its data
//   reg_rd_en, reg_rd_data   one-cycle read strobe. The data is valid
//                            exactly one clk after the strobe.
//   busy                     set between START and STOP, for any address
//   addressed                the current transaction matched DEV_ADDR
// ---------------------------------------------------------------------------

// Pin conditioner: 2-FF synchroniser followed by a run-length glitch filter.
//   clk, rst_n   clock and asynchronous active-low reset
//   pin          raw asynchronous pin
//   level        filtered level. Idles high, like a pulled-up bus line.
module i2c_slave_regs_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level
);

  localparam int CW = $clog2(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // The counter tracks how many consecutive synced samples disagree with the
  // filtered level. Any agreeing sample restarts the count, so a pulse
  // shorter than FILTER_LEN samples never reaches the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

module i2c_slave_regs #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl_i,
  output logic       i2c_scl_o,
  output logic       i2c_scl_t,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_t,
  output logic [7:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_data,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rd_data,
  output logic       busy,
  output logic       addressed
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  // The slave only ever pulls SDA low. SCL is input-only.
  assign i2c_scl_o = 1'b0;
  assign i2c_scl_t = 1'b1;
  assign i2c_sda_o = 1'b0;

  // Reset asserts asynchronously and releases on a clock edge. When rst_n
  // falls, the core reset follows at once, so SDA is released without
  // waiting for a clk edge.
  logic [1:0] rst_pipe;
  logic       rst_core_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_core_n = rst_pipe[1];

  logic scl_f, sda_f, scl_d, sda_d;

  i2c_slave_regs_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk   (clk),
    .rst_n (rst_core_n),
    .pin   (i2c_scl_i),
    .level (scl_f)
  );

  i2c_slave_regs_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk   (clk),
    .rst_n (rst_core_n),
    .pin   (i2c_sda_i),
    .level (sda_f)
  );

  // Delayed copies of the filtered lines give one-cycle edge pulses.
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_cond, stop_cond;

  assign scl_rise   =  scl_f & ~scl_d;
  assign scl_fall   = ~scl_f &  scl_d;
  assign start_cond =  scl_f &  sda_d & ~sda_f;
  assign stop_cond  =  scl_f & ~sda_d &  sda_f;

  state_t     state, state_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [6:0] shift, shift_next;
  logic [7:0] tx, tx_next;
  logic [7:0] ptr, ptr_next;
  logic       rw, rw_next;
  logic       rd_latch, rd_latch_next;
  logic       sda_t_next, busy_next, addressed_next;
  logic       wr_en_next, rd_en_next;
  logic [7:0] reg_addr_next, wr_data_next;
  logic [7:0] rx_byte;

  // This block holds all registered state: the FSM state, the bit and byte
  // datapath, and every registered output. The reset values leave the bus
  // released and the slave idle.
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      tx          <= '0;
      ptr         <= '0;
      rw          <= 1'b0;
      rd_latch    <= 1'b0;
      i2c_sda_t   <= 1'b1;
      busy        <= 1'b0;
      addressed   <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      shift       <= shift_next;
      tx          <= tx_next;
      ptr         <= ptr_next;
      rw          <= rw_next;
      rd_latch    <= rd_latch_next;
      i2c_sda_t   <= sda_t_next;
      busy        <= busy_next;
      addressed   <= addressed_next;
      reg_wr_en   <= wr_en_next;
      reg_rd_en   <= rd_en_next;
      reg_addr    <= reg_addr_next;
      reg_wr_data <= wr_data_next;
    end
  end

  // Next-state and output logic.
  //
  // Incoming bits are shifted in on SCL rising edges. The slave changes SDA
  // only in the clk after an SCL falling edge.
  //
  // In the ACK states, the current SDA drive tells which falling edge this
  // is. If SDA is still released, this is the falling edge of bit 8, so the
  // slave starts the ACK. Otherwise it is the falling edge of bit 9, which
  // ends the ACK.
  //
  // Read data is captured in the cycle after reg_rd_en. That is also the
  // point where the pointer advances. If the capture happens while the FSM
  // is already in RD_DATA (a follow-on byte), the MSB is put on SDA right
  // away. SCL is still low at that point.
  //
  // START and STOP are evaluated last, so they take priority from any state.
  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    tx_next        = tx;
    ptr_next       = ptr;
    rw_next        = rw;
    rd_latch_next  = reg_rd_en;
    sda_t_next     = i2c_sda_t;
    busy_next      = busy;
    addressed_next = addressed;
    wr_en_next     = 1'b0;
    rd_en_next     = 1'b0;
    reg_addr_next  = reg_addr;
    wr_data_next   = reg_wr_data;
    rx_byte        = {shift, sda_f};

    if (rd_latch) begin
      tx_next  = reg_rd_data;
      ptr_next = ptr + 8'd1;
      if (state == RD_DATA) sda_t_next = reg_rd_data[7];
    end

    case (state)
      ADDR: begin
        if (scl_rise) begin
          shift_next = rx_byte[6:0];
          if (bit_cnt == 3'd7) begin
            bit_cnt_next = '0;
            if (rx_byte[7:1] == DEV_ADDR) begin
              addressed_next = 1'b1;
              rw_next        = rx_byte[0];
              state_next     = ADDR_ACK;
            end else begin
              state_next = WAIT_STOP;
            end
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end

      ADDR_ACK: begin
        if (scl_fall) begin
          if (i2c_sda_t) begin
            sda_t_next = 1'b0;
            if (rw) begin
              rd_en_next    = 1'b1;
              reg_addr_next = ptr;
            end
          end else if (rw) begin
            state_next   = RD_DATA;
            bit_cnt_next = '0;
            sda_t_next   = tx[7];
          end else begin
            state_next   = PTR;
            bit_cnt_next = '0;
            sda_t_next   = 1'b1;
          end
        end
      end

      PTR: begin
        if (scl_rise) begin
          shift_next = rx_byte[6:0];
          if (bit_cnt == 3'd7) begin
            bit_cnt_next = '0;
            ptr_next     = rx_byte;
            state_next   = PTR_ACK;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end

      PTR_ACK, WR_ACK: begin
        if (scl_fall) begin
          if (i2c_sda_t) begin
            sda_t_next = 1'b0;
          end else begin
            sda_t_next   = 1'b1;
            bit_cnt_next = '0;
            state_next   = WR_DATA;
          end
        end
      end

      WR_DATA: begin
        if (scl_rise) begin
          shift_next = rx_byte[6:0];
          if (bit_cnt == 3'd7) begin
            bit_cnt_next  = '0;
            wr_en_next    = 1'b1;
            reg_addr_next = ptr;
            wr_data_next  = rx_byte;
            ptr_next      = ptr + 8'd1;
            state_next    = WR_ACK;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end

      RD_DATA: begin
        if (scl_fall) begin
          if (bit_cnt == 3'd7) begin
            bit_cnt_next = '0;
            sda_t_next   = 1'b1;
            state_next   = RD_ACK;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            tx_next      = {tx[6:0], 1'b1};
            sda_t_next   = tx[6];
          end
        end
      end

      RD_ACK: begin
        if (scl_rise) begin
          shift_next = rx_byte[6:0];
        end else if (scl_fall) begin
          sda_t_next = 1'b1;
          if (!shift[0]) begin
            rd_en_next    = 1'b1;
            reg_addr_next = ptr;
            bit_cnt_next  = '0;
            state_next    = RD_DATA;
          end else begin
            state_next = WAIT_STOP;
          end
        end
      end

      default: ;
    endcase

    if (start_cond) begin
      state_next     = ADDR;
      bit_cnt_next   = '0;
      busy_next      = 1'b1;
      addressed_next = 1'b0;
      sda_t_next     = 1'b1;
    end

    if (stop_cond) begin
      state_next     = IDLE;
      busy_next      = 1'b0;
      addressed_next = 1'b0;
      sda_t_next     = 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regs
//
// Bench for i2c_slave_regs. A behavioural I2C master runs at 100 kHz against
// a 10 MHz system clock.
//
// Scoreboard
//   Expected register writes, read-strobe addresses and read bytes are
//   queued when the master drives the matching bus traffic. They are popped
//   when the DUT produces the strobe, or when the master receives the byte.
//
// Register model
//   The read side returns addr+1, valid exactly one clk after reg_rd_en.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2c_slave_regs;

  localparam time Q = 2500ns;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       scl_line, sda_line;
  logic       i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t;
  logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
  logic       reg_wr_en, reg_rd_en, busy, addressed;

  int passCount = 0;
  int checkCount = 0;

  logic [15:0] wrQ[$];
  logic [7:0]  rdAddrQ[$];
  logic [7:0]  rdByteQ[$];
  logic        sdaLowSeen = 1'b0;

  logic       rdPend = 1'b0;
  logic [7:0] rdPendAddr = 8'h00;

  // 10 MHz system clock.
  always #50 clk = ~clk;

  // Open-drain wiring: each line is low if either side pulls it low.
  assign scl_line = scl_drv & (i2c_scl_t | i2c_scl_o);
  assign sda_line = sda_drv & (i2c_sda_t | i2c_sda_o);

  i2c_slave_regs #(.DEV_ADDR(7'h50), .FILTER_LEN(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i2c_scl_i   (scl_line),
    .i2c_scl_o   (i2c_scl_o),
    .i2c_scl_t   (i2c_scl_t),
    .i2c_sda_i   (sda_line),
    .i2c_sda_o   (i2c_sda_o),
    .i2c_sda_t   (i2c_sda_t),
    .reg_addr    (reg_addr),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_data (reg_wr_data),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_data (reg_rd_data),
    .busy        (busy),
    .addressed   (addressed)
  );

  // Every comparison in the bench goes through this task.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Register model. reg_rd_data carries addr+1 only in the cycle after the
  // strobe. At all other times it shows a filler value.
  always @(negedge clk) begin
    reg_rd_data = rdPend ? (rdPendAddr + 8'd1) : 8'hEE;
    rdPend      = reg_rd_en;
    rdPendAddr  = reg_addr;
  end

  // Strobe monitor. It pops the scoreboard on each strobe and records any
  // SDA drive by the slave.
  always @(negedge clk) begin
    if (!i2c_sda_t) sdaLowSeen = 1'b1;
    if (reg_wr_en || reg_rd_en)
      checkOutput("strobe_exclusive", 32'(reg_wr_en & reg_rd_en), 32'd0);
    if (reg_wr_en) begin
      checkOutput("wr_expected", 32'(wrQ.size() > 0), 32'd1);
      if (wrQ.size() > 0) checkOutput("wr_addr_data", 32'({reg_addr, reg_wr_data}), 32'(wrQ.pop_front()));
    end
    if (reg_rd_en) begin
      checkOutput("rd_expected", 32'(rdAddrQ.size() > 0), 32'd1);
      if (rdAddrQ.size() > 0) checkOutput("rd_addr", 32'(reg_addr), 32'(rdAddrQ.pop_front()));
    end
  end

  // Bus primitives for a 100 kHz master. Each bit takes four quarter periods.
  task automatic startCond();
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic stopCond();
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b1; #Q;
  endtask

  task automatic sendBit(input logic b, input bit glitch);
    sda_drv = b; #Q;
    scl_drv = 1'b1; #Q;
    if (glitch) begin
      scl_drv = 1'b0; #200ns;
      scl_drv = 1'b1; #(Q - 200ns);
    end else begin
      #Q;
    end
    scl_drv = 1'b0; #Q;
  endtask

  task automatic recvBit(output logic b);
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    b = sda_line; #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic writeByte(input logic [7:0] b, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(b[i], glitch && (i == 4));
    recvBit(ack);
  endtask

  task automatic readByte(input bit masterAck, output logic [7:0] d);
    logic bitVal;
    for (int i = 7; i >= 0; i--) begin
      recvBit(bitVal);
      d[i] = bitVal;
    end
    sendBit(!masterAck, 1'b0);
  endtask

  // One write transaction: pointer, then one or two data bytes, then STOP.
  // The expected register writes are queued as each data byte is driven.
  task automatic applyStimulus(input string name, input logic [7:0] ptr, input logic [7:0] d0,
                               input logic [7:0] d1, input int nBytes, input bit glitch);
    logic       ack;
    logic [7:0] p;
    startCond();
    checkOutput({name, "_busy_start"}, 32'(busy), 32'd1);
    writeByte(8'hA0, 1'b0, ack);
    checkOutput({name, "_addr_ack"}, 32'(ack), 32'd0);
    checkOutput({name, "_addressed"}, 32'(addressed), 32'd1);
    writeByte(ptr, 1'b0, ack);
    checkOutput({name, "_ptr_ack"}, 32'(ack), 32'd0);
    p = ptr;
    wrQ.push_back({p, d0});
    writeByte(d0, glitch, ack);
    checkOutput({name, "_d0_ack"}, 32'(ack), 32'd0);
    p = p + 8'd1;
    if (nBytes > 1) begin
      wrQ.push_back({p, d1});
      writeByte(d1, 1'b0, ack);
      checkOutput({name, "_d1_ack"}, 32'(ack), 32'd0);
    end
    stopCond();
    checkOutput({name, "_busy_stop"}, 32'(busy), 32'd0);
    checkOutput({name, "_addressed_stop"}, 32'(addressed), 32'd0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;

    // Reset state.
    #350ns rst_n = 1'b1;
    #1000ns;
    checkOutput("rst_sda_t", 32'(i2c_sda_t), 32'd1);
    checkOutput("rst_wr_en", 32'(reg_wr_en), 32'd0);
    checkOutput("rst_rd_en", 32'(reg_rd_en), 32'd0);
    checkOutput("rst_reg_addr", 32'(reg_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(reg_wr_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_addressed", 32'(addressed), 32'd0);
    checkOutput("rst_scl_t", 32'(i2c_scl_t), 32'd1);

    // Two-byte write with pointer auto-increment.
    applyStimulus("write", 8'h10, 8'hAB, 8'hCD, 2, 1'b0);

    // Random read: set the pointer, send a repeated START, then read two
    // bytes, ACKing the first and NACKing the second.
    startCond();
    writeByte(8'hA0, 1'b0, ack);
    checkOutput("read_addr_w_ack", 32'(ack), 32'd0);
    writeByte(8'h20, 1'b0, ack);
    checkOutput("read_ptr_ack", 32'(ack), 32'd0);
    rdAddrQ.push_back(8'h20);
    rdAddrQ.push_back(8'h21);
    rdByteQ.push_back(8'h21);
    rdByteQ.push_back(8'h22);
    startCond();
    writeByte(8'hA1, 1'b0, ack);
    checkOutput("read_addr_r_ack", 32'(ack), 32'd0);
    readByte(1'b1, d);
    checkOutput("read_byte0", 32'(d), 32'(rdByteQ.pop_front()));
    readByte(1'b0, d);
    checkOutput("read_byte1", 32'(d), 32'(rdByteQ.pop_front()));
    stopCond();
    checkOutput("read_busy_stop", 32'(busy), 32'd0);

    // Address mismatch: the slave must never touch SDA.
    sdaLowSeen = 1'b0;
    startCond();
    checkOutput("mis_busy_start", 32'(busy), 32'd1);
    writeByte(8'hA2, 1'b0, ack);
    checkOutput("mis_addr_nack", 32'(ack), 32'd1);
    checkOutput("mis_addressed", 32'(addressed), 32'd0);
    writeByte(8'h55, 1'b0, ack);
    checkOutput("mis_data_nack", 32'(ack), 32'd1);
    stopCond();
    checkOutput("mis_busy_stop", 32'(busy), 32'd0);
    checkOutput("mis_sda_never_driven", 32'(sdaLowSeen), 32'd0);

    // Pointer wrap from 0xFF to 0x00.
    applyStimulus("wrap", 8'hFF, 8'h01, 8'h02, 2, 1'b0);

    // A short SCL glitch in the middle of a data byte must be ignored.
    applyStimulus("glitch", 8'h40, 8'h3C, 8'h00, 1, 1'b1);

    // Async reset while the slave drives a 0 data bit (byte 0x31, MSB 0).
    startCond();
    writeByte(8'hA0, 1'b0, ack);
    writeByte(8'h30, 1'b0, ack);
    rdAddrQ.push_back(8'h30);
    startCond();
    writeByte(8'hA1, 1'b0, ack);
    checkOutput("arst_addr_r_ack", 32'(ack), 32'd0);
    checkOutput("arst_driving_zero", 32'(i2c_sda_t), 32'd0);
    #7ns rst_n = 1'b0;
    #1ns;
    checkOutput("arst_sda_released", 32'(i2c_sda_t), 32'd1);
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    #300ns rst_n = 1'b1;
    #1000ns;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    applyStimulus("post_rst", 8'h60, 8'h77, 8'h00, 1, 1'b0);

    // Every queued expectation must have been consumed.
    #1000ns;
    checkOutput("wr_queue_drained", 32'(wrQ.size()), 32'd0);
    checkOutput("rd_queue_drained", 32'(rdAddrQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (responder) giving host-side I2C masters access to an 8-bit register space inside the FPGA.
- Connects to the split i2c_*_i/_o/_t pins in the same way the top level already does for the I2C master: line = t ? z : o.
- Handles START/STOP detection, 7-bit address match, register pointer load and auto-incrementing reads/writes to a simple synchronous register port.
- No clock stretching. Expects clk >= 100x the SCL rate.

Parameters:
- DEV_ADDR, 7'h50, 7-bit I2C device address to respond to.
- FILTER_LEN, 4, number of consecutive identical synchronised samples required before filtered SCL/SDA change (>= 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i2c_scl_i  in  1  SCL pin input
- i2c_scl_o  out  1  SCL output, constant 0
- i2c_scl_t  out  1  SCL tristate, constant 1 (never driven)
- i2c_sda_i  in  1  SDA pin input
- i2c_sda_o  out  1  SDA output, constant 0
- i2c_sda_t  out  1  SDA tristate; 0 = pull SDA low
- reg_addr  out  8  register address for the current access
- reg_wr_en  out  1  one-cycle write strobe
- reg_wr_data  out  8  write data, valid with reg_wr_en
- reg_rd_en  out  1  one-cycle read strobe
- reg_rd_data  in  8  read data, valid exactly one clk after reg_rd_en
- busy  out  1  bus active: between START and STOP, any address
- addressed  out  1  current transaction matched DEV_ADDR

Behaviour:
- Reset (async assert, sync release): i2c_sda_t=1; reg_wr_en=0, reg_rd_en=0; reg_addr=0, reg_wr_data=0; busy=0, addressed=0; pointer=0; state IDLE.
- Input conditioning:
  - 2-FF synchroniser on each pin.
  - Filtered value updates only after FILTER_LEN consecutive equal synced samples.
  - SCL rise/fall and SDA rise/fall are one-cycle pulses derived from the filtered values.
- START = filtered SDA falls while filtered SCL is high. STOP = filtered SDA rises while filtered SCL is high.
  - START in any state: go to ADDR, clear bit counter, busy=1, release SDA.
  - STOP in any state: go to IDLE, busy=0, addressed=0, release SDA.
- Bits are sampled on the SCL rising edge. SDA output changes only on the clk after an SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - Bits [7:1] == DEV_ADDR: addressed=1, go to ADDR_ACK.
    - Otherwise: go to WAIT_STOP, SDA never driven.
  - ADDR_ACK: drive SDA low for the 9th clock, release after its falling edge.
    - R/W=0: go to PTR.
    - R/W=1: pulse reg_rd_en with reg_addr=pointer on the 8th-bit falling edge (before ACK); latch reg_rd_data the next clk; go to RD_DATA after the ACK.
  - PTR: shift 8 bits, load pointer, go to PTR_ACK (ACK the byte), then WR_DATA.
  - WR_DATA: on the 8th bit rising edge, pulse reg_wr_en with reg_addr=pointer and reg_wr_data=byte; pointer+1 (8-bit wrap 0xFF->0x00); go to WR_ACK (ACK the byte), then WR_DATA.
  - RD_DATA: drive shift register MSB-first. A 1 bit releases SDA; a 0 bit sets sda_t=0. Pointer+1 at the load. After 8 bits, release SDA, go to RD_ACK.
  - RD_ACK: sample the master's bit on the 9th rising edge.
    - ACK (0): issue reg_rd_en on the 9th falling edge and reload; go to RD_DATA.
    - NACK: go to WAIT_STOP, no fetch.
  - WAIT_STOP: SDA released; wait for STOP/START.
- Repeated START after PTR keeps the pointer (standard register-read sequence).
- SDA is never driven outside ACK slots and RD_DATA bits.
- reg_rd_en and reg_wr_en are never asserted in the same cycle.

Test Plan:
- Write: START, 0xA0, 0x10, 0xAB, 0xCD, STOP at 100 kHz -> slave ACKs all 4 bytes; reg_wr_en pulses twice: (0x10, 0xAB) then (0x11, 0xCD); busy falls at STOP.
- Random read: START, 0xA0, 0x20, Sr, 0xA1; model returns addr+1; master ACKs byte 1, NACKs byte 2; STOP -> bytes 0x21, 0x22 on SDA; exactly two reg_rd_en, at addresses 0x20 and 0x21.
- Mismatch: START, 0xA2, 0x55, STOP -> i2c_sda_t stays 1 throughout; no strobes; addressed=0; busy 1 then 0.
- Wrap: pointer 0xFF, write 0x01, 0x02 -> writes land at 0xFF then 0x00.
- Glitch: 2-clk low pulse on SCL mid-byte with FILTER_LEN=4 -> ignored; byte still received correctly.
- Async reset while the slave drives a 0 data bit -> i2c_sda_t=1 within the same cycle, no clk edge needed; after release a new write transaction succeeds.
